// File: rtl/sha1_block_packer.sv
// SHA-1 block packer: forms padded message words and packs them into 16-word blocks.
// Build option SHA1_PACK_DOUBLE_BUF_EN selects ping-pong double buffering; otherwise a single bank.
module sha1_block_packer #(
  parameter int BLOCK_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] message_size,
  input  logic [31:0] port_A_data,
  input  logic        word_valid,
  input  logic        port,
  input  logic        concat_one,
  input  logic        zero,
  input  logic        upper_32,
  input  logic        lower_32,
  output logic        word_ready,
  output logic        block_valid,
  input  logic        block_ready,
  output logic        last_block,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] blocks_done
);

`ifdef SHA1_PACK_DOUBLE_BUF_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t state_q [NUM_BANKS];
  bank_state_t state_d [NUM_BANKS];

  logic [31:0]          bank_mem [NUM_BANKS][BLOCK_WORDS];
  logic [NUM_BANKS-1:0] last_q;
  logic [3:0]           word_cnt;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [31:0]          blocks_done_q;

  logic [31:0] word_d;
  logic        is_len_lo;
  logic        accept;
  logic        handshake;
  logic        last_word;

  assign accept    = word_valid & word_ready;
  assign handshake = block_valid & block_ready;
  assign last_word = (word_cnt == 4'(BLOCK_WORDS - 1));

  // Source selects resolve by fixed priority; only the lower length word marks a block as last.
  always_comb begin
    word_d    = 32'h0000_0000;
    is_len_lo = 1'b0;
    if (port) begin
      word_d = port_A_data;
    end else if (concat_one) begin
      case (message_size[1:0])
        2'd0:    word_d = 32'h8000_0000;
        2'd1:    word_d = {port_A_data[31:24], 24'h80_0000};
        2'd2:    word_d = {port_A_data[31:16], 16'h8000};
        default: word_d = {port_A_data[31:8], 8'h80};
      endcase
    end else if (zero) begin
      word_d = 32'h0000_0000;
    end else if (upper_32) begin
      word_d = {29'b0, message_size[31:29]};
    end else if (lower_32) begin
      word_d    = {message_size[28:0], 3'b000};
      is_len_lo = 1'b1;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b] = state_q[b];
      if (start) begin
        state_d[b] = EMPTY;
      end else begin
        if (handshake && (rd_bank == b[0])) state_d[b] = EMPTY;
        if (accept && (wr_bank == b[0])) state_d[b] = last_word ? FULL : FILLING;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (reset) state_q[b] <= EMPTY;
      else       state_q[b] <= state_d[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      word_cnt      <= 4'd0;
      blocks_done_q <= 32'd0;
      last_q        <= '0;
    end else begin
      if (accept)    word_cnt      <= word_cnt + 4'd1;
      if (handshake) blocks_done_q <= blocks_done_q + 32'd1;
      if (handshake) last_q[rd_bank] <= 1'b0;
      if (accept && is_len_lo) last_q[wr_bank] <= 1'b1;
    end
  end

  // A word coinciding with start or reset is dropped, never written.
  always_ff @(posedge clk) begin
    if (accept && !reset && !start) bank_mem[wr_bank][word_cnt] <= word_d;
  end

`ifdef SHA1_PACK_DOUBLE_BUF_EN
  // Both pointers toggle in lockstep order, so blocks leave in the order they were filled.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (accept && last_word) wr_bank <= ~wr_bank;
      if (handshake)           rd_bank <= ~rd_bank;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  assign word_ready  = (state_q[wr_bank] != FULL);
  assign block_valid = (state_q[rd_bank] == FULL);
  assign last_block  = block_valid & last_q[rd_bank];
  assign rd_data     = bank_mem[rd_bank][rd_addr];
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_sha1_block_packer.sv
// Directed bench for sha1_block_packer: padding words, block hand-off, stalls, start and reset.
// Double-buffer checks are compiled in when SHA1_PACK_DOUBLE_BUF_EN is defined.
module tb_sha1_block_packer;

  localparam logic [4:0] SEL_PORT   = 5'b10000;
  localparam logic [4:0] SEL_CONCAT = 5'b01000;
  localparam logic [4:0] SEL_ZERO   = 5'b00100;
  localparam logic [4:0] SEL_UPPER  = 5'b00010;
  localparam logic [4:0] SEL_LOWER  = 5'b00001;

`ifdef SHA1_PACK_DOUBLE_BUF_EN
  localparam logic READY_WHEN_ONE_FULL = 1'b1;
`else
  localparam logic READY_WHEN_ONE_FULL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] message_size;
  logic [31:0] port_A_data;
  logic        word_valid;
  logic        port;
  logic        concat_one;
  logic        zero;
  logic        upper_32;
  logic        lower_32;
  logic        word_ready;
  logic        block_valid;
  logic        block_ready;
  logic        last_block;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] blocks_done;

  int compared   = 0;
  int mismatched = 0;

  sha1_block_packer #(.BLOCK_WORDS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .message_size(message_size),
    .port_A_data(port_A_data), .word_valid(word_valid), .port(port),
    .concat_one(concat_one), .zero(zero), .upper_32(upper_32), .lower_32(lower_32),
    .word_ready(word_ready), .block_valid(block_valid), .block_ready(block_ready),
    .last_block(last_block), .rd_addr(rd_addr), .rd_data(rd_data), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Offers one word (called on a falling edge) and returns on the falling edge after it is taken.
  task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] data);
    int n;
    n = 0;
    {port, concat_one, zero, upper_32, lower_32} = sel;
    port_A_data = data;
    word_valid  = 1'b1;
    while (!word_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) checkOutput("ready_timeout", 32'(word_ready), 32'd1);
    @(negedge clk);
    word_valid = 1'b0;
    {port, concat_one, zero, upper_32, lower_32} = 5'b0;
  endtask

  task automatic readWord(input logic [3:0] idx, input string tag, input logic [31:0] exp);
    rd_addr = idx;
    #1;
    checkOutput(tag, rd_data, exp);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseBlockReady();
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; message_size = 32'd0; port_A_data = 32'd0;
    word_valid = 1'b0; {port, concat_one, zero, upper_32, lower_32} = 5'b0;
    block_ready = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_word_ready", 32'(word_ready), 32'd1);
    checkOutput("rst_block_valid", 32'(block_valid), 32'd0);
    checkOutput("rst_last_block", 32'(last_block), 32'd0);
    checkOutput("rst_blocks_done", blocks_done, 32'd0);

    // "abc"
    message_size = 32'd3;
    pulseStart();
    applyStimulus(SEL_CONCAT, 32'h6162_6300);
    for (int i = 0; i < 13; i++) applyStimulus(SEL_ZERO, 32'hFFFF_FFFF);
    applyStimulus(SEL_UPPER, 32'hFFFF_FFFF);
    applyStimulus(SEL_LOWER, 32'hFFFF_FFFF);
    checkOutput("abc_block_valid", 32'(block_valid), 32'd1);
    checkOutput("abc_word_ready", 32'(word_ready), 32'(READY_WHEN_ONE_FULL));
    checkOutput("abc_last_block", 32'(last_block), 32'd1);
    checkOutput("abc_blocks_done0", blocks_done, 32'd0);
    readWord(4'd0, "abc_w0", 32'h6162_6380);
    readWord(4'd1, "abc_w1", 32'h0000_0000);
    readWord(4'd13, "abc_w13", 32'h0000_0000);
    readWord(4'd14, "abc_w14", 32'h0000_0000);
    readWord(4'd15, "abc_w15", 32'h0000_0018);
    @(negedge clk);
    pulseBlockReady();
    checkOutput("abc_blocks_done1", blocks_done, 32'd1);
    checkOutput("abc_valid_drop", 32'(block_valid), 32'd0);
    checkOutput("abc_last_drop", 32'(last_block), 32'd0);
    checkOutput("abc_ready_back", 32'(word_ready), 32'd1);

    // "abcd", other residues and multi-hot priority
    message_size = 32'd4;
    pulseStart();
    checkOutput("abcd_blocks_done", blocks_done, 32'd0);
    applyStimulus(SEL_PORT, 32'h6162_6364);
    applyStimulus(SEL_CONCAT, 32'hFFFF_FFFF);
    message_size = 32'd1;
    applyStimulus(SEL_CONCAT, 32'hAABB_CCDD);
    message_size = 32'd2;
    applyStimulus(SEL_CONCAT | SEL_UPPER, 32'hAABB_CCDD);
    applyStimulus(SEL_PORT | SEL_ZERO, 32'h1234_5678);
    applyStimulus(SEL_ZERO | SEL_LOWER, 32'h1234_5678);
    message_size = 32'd3;
    applyStimulus(SEL_CONCAT, 32'hAABB_CCDD);
    for (int i = 0; i < 9; i++) applyStimulus(SEL_ZERO, 32'h0);
    checkOutput("abcd_block_valid", 32'(block_valid), 32'd1);
    checkOutput("abcd_last_block", 32'(last_block), 32'd0);
    readWord(4'd0, "abcd_w0", 32'h6162_6364);
    readWord(4'd1, "abcd_w1", 32'h8000_0000);
    readWord(4'd2, "r1_concat", 32'hAA80_0000);
    readWord(4'd3, "prio_concat_upper", 32'hAABB_8000);
    readWord(4'd4, "prio_port_zero", 32'h1234_5678);
    readWord(4'd5, "prio_zero_lower", 32'h0000_0000);
    readWord(4'd6, "r3_concat", 32'hAABB_CC80);
    @(negedge clk);
    pulseBlockReady();

`ifdef SHA1_PACK_DOUBLE_BUF_EN
    // 33 words offered with the engine stalled
    message_size = 32'd64;
    pulseStart();
    for (int i = 0; i < 32; i++) applyStimulus(SEL_PORT, 32'(i + 1));
    checkOutput("dbl_ready_low", 32'(word_ready), 32'd0);
    checkOutput("dbl_valid", 32'(block_valid), 32'd1);
    readWord(4'd0, "dbl_first_w0", 32'd1);
    readWord(4'd15, "dbl_first_w15", 32'd16);
    @(negedge clk);
    port = 1'b1; port_A_data = 32'h21; word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("dbl_hold", 32'(word_ready), 32'd0);
    end
    pulseBlockReady();
    checkOutput("dbl_hs1_count", blocks_done, 32'd1);
    checkOutput("dbl_hs1_valid", 32'(block_valid), 32'd1);
    checkOutput("dbl_hs1_ready", 32'(word_ready), 32'd1);
    readWord(4'd0, "dbl_second_w0", 32'd17);
    readWord(4'd15, "dbl_second_w15", 32'd32);
    @(negedge clk);
    word_valid = 1'b0; port = 1'b0;
    pulseBlockReady();
    checkOutput("dbl_hs2_count", blocks_done, 32'd2);
    checkOutput("dbl_hs2_valid", 32'(block_valid), 32'd0);
`else
    // 17 words offered with the engine stalled
    message_size = 32'd64;
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(SEL_PORT, 32'(i + 1));
    checkOutput("sgl_ready_low", 32'(word_ready), 32'd0);
    checkOutput("sgl_valid", 32'(block_valid), 32'd1);
    port = 1'b1; port_A_data = 32'h11; word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("sgl_hold", 32'(word_ready), 32'd0);
    end
    readWord(4'd0, "sgl_first_w0", 32'd1);
    readWord(4'd15, "sgl_first_w15", 32'd16);
    @(negedge clk);
    pulseBlockReady();
    checkOutput("sgl_hs_ready", 32'(word_ready), 32'd1);
    checkOutput("sgl_hs_valid", 32'(block_valid), 32'd0);
    checkOutput("sgl_hs_count", blocks_done, 32'd1);
    @(negedge clk);
    word_valid = 1'b0; port = 1'b0;
    for (int i = 1; i < 16; i++) applyStimulus(SEL_PORT, 32'(32'h11 + i));
    checkOutput("sgl_next_valid", 32'(block_valid), 32'd1);
    readWord(4'd0, "sgl_next_w0", 32'h11);
    readWord(4'd1, "sgl_next_w1", 32'h12);
    readWord(4'd15, "sgl_next_w15", 32'h20);
    @(negedge clk);
    pulseBlockReady();
    checkOutput("sgl_hs2_count", blocks_done, 32'd2);
`endif

    // start after 5 words, with a word offered in the same cycle
    message_size = 32'd64;
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(SEL_PORT, 32'(32'hA0 + i));
    start = 1'b1; port = 1'b1; port_A_data = 32'hDEAD; word_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; port = 1'b0; word_valid = 1'b0;
    checkOutput("st_blocks_done", blocks_done, 32'd0);
    for (int i = 0; i < 15; i++) applyStimulus(SEL_PORT, 32'(32'h100 + i));
    checkOutput("st_valid_after15", 32'(block_valid), 32'd0);
    applyStimulus(SEL_PORT, 32'h10F);
    checkOutput("st_valid_after16", 32'(block_valid), 32'd1);
    readWord(4'd0, "st_w0", 32'h100);
    readWord(4'd15, "st_w15", 32'h10F);
    @(negedge clk);

    // length words with bit 29 set, then reset mid-block
    message_size = 32'h2000_0000;
    pulseStart();
    checkOutput("len_pending_dropped", 32'(block_valid), 32'd0);
    applyStimulus(SEL_UPPER, 32'hFFFF_FFFF);
    applyStimulus(SEL_LOWER, 32'hFFFF_FFFF);
    for (int i = 0; i < 14; i++) applyStimulus(SEL_ZERO, 32'hFFFF_FFFF);
    checkOutput("len_valid", 32'(block_valid), 32'd1);
    checkOutput("len_last", 32'(last_block), 32'd1);
    readWord(4'd0, "len_upper", 32'h0000_0001);
    readWord(4'd1, "len_lower", 32'h0000_0000);
    @(negedge clk);
    pulseBlockReady();
    for (int i = 0; i < 15; i++) applyStimulus(SEL_ZERO, 32'h0);
    checkOutput("pre_rst_count", blocks_done, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_word_ready", 32'(word_ready), 32'd1);
    checkOutput("mid_rst_block_valid", 32'(block_valid), 32'd0);
    checkOutput("mid_rst_last_block", 32'(last_block), 32'd0);
    checkOutput("mid_rst_blocks_done", blocks_done, 32'd0);
    reset = 1'b0;
    applyStimulus(SEL_ZERO, 32'h0);
    checkOutput("post_rst_cnt_cleared", 32'(block_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
